id_ex_operand_stage: RTL

- ID/EX pipeline stage for the five-stage MIPS core; sits directly upstream of the ALU.
- Registers decoded operands and control, then resolves data hazards.
- Selects ALU operand A and B and drives the ALU inputs: A, B, ALUFun[5:0], Sign.
- Forwards results from the EX/MEM and MEM/WB stages, and detects load-use hazards, inserting one bubble per hazard.

---
 rtl/id_ex_operand_stage.sv | 260 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/id_ex_operand_stage.sv
// ----------------------------------------------------------------------------
// id_ex_operand_stage
//
// ID/EX pipeline register for the five-stage MIPS core, followed by the
// operand-resolution logic that feeds the ALU directly.
//
// Configuration macro: OPERAND_FORWARD_EN
//   defined   : rs/rt are forwarded from EX/MEM (first) or MEM/WB. Only
//               load-use dependencies on the EX slot raise hazard_stall.
//   undefined : no forwarding muxes. Operands come from the latched
//               register-file data. hazard_stall is raised for any RAW
//               dependency on the EX slot or on EX/MEM.
//
// Ports
//   clk, reset                 rising-edge clock, async active-low reset
//   stall, flush               external freeze / squash of the EX slot
//   id_*                       decoded instruction presented by ID
//   exmem_*, memwb_*           forwarding sources (writer regwrite/rd/result)
//   ex_valid                   EX slot holds a real instruction
//   ex_a, ex_b                 ALU operands A and B
//   ex_alufun, ex_sign         ALU function code and signed flag
//   ex_store_data              forwarded rt, for stores
//   ex_rd, ex_regwrite,
//   ex_memread, ex_memwrite    control carried on to MEM
//   hazard_stall               combinational; upstream holds PC and IF/ID
//
// Handshake: ex_valid qualifies every ex_* output (they all read 0 when it is
// low). hazard_stall is a same-cycle back-pressure signal. While it is high
// this stage loads a bubble and the upstream stages must present the same ID
// instruction again on the next cycle.
// ----------------------------------------------------------------------------
module id_ex_operand_stage #(
    parameter int DW        = 32,
    parameter int LUI_SHAMT = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          stall,
    input  logic          flush,
    input  logic          id_valid,
    input  logic [4:0]    id_rs_addr,
    input  logic [4:0]    id_rt_addr,
    input  logic          id_use_rs,
    input  logic          id_use_rt,
    input  logic [DW-1:0] id_rs_data,
    input  logic [DW-1:0] id_rt_data,
    input  logic [DW-1:0] id_imm,
    input  logic [4:0]    id_shamt,
    input  logic [1:0]    id_alusrc_a,
    input  logic          id_alusrc_b,
    input  logic [5:0]    id_alufun,
    input  logic          id_sign,
    input  logic [4:0]    id_rd_addr,
    input  logic          id_regwrite,
    input  logic          id_memread,
    input  logic          id_memwrite,
    input  logic          exmem_regwrite,
    input  logic [4:0]    exmem_rd,
    input  logic [DW-1:0] exmem_result,
    input  logic          memwb_regwrite,
    input  logic [4:0]    memwb_rd,
    input  logic [DW-1:0] memwb_result,
    output logic          ex_valid,
    output logic [DW-1:0] ex_a,
    output logic [DW-1:0] ex_b,
    output logic [5:0]    ex_alufun,
    output logic          ex_sign,
    output logic [DW-1:0] ex_store_data,
    output logic [4:0]    ex_rd,
    output logic          ex_regwrite,
    output logic          ex_memread,
    output logic          ex_memwrite,
    output logic          hazard_stall
);

    // ------------------------------------------------------------------
    // Stage registers
    // ------------------------------------------------------------------
    logic          valid_q,    valid_d;
    logic [4:0]    rs_addr_q,  rs_addr_d;
    logic [4:0]    rt_addr_q,  rt_addr_d;
    logic [DW-1:0] rs_data_q,  rs_data_d;
    logic [DW-1:0] rt_data_q,  rt_data_d;
    logic [DW-1:0] imm_q,      imm_d;
    logic [4:0]    shamt_q,    shamt_d;
    logic [1:0]    alusrc_a_q, alusrc_a_d;
    logic          alusrc_b_q, alusrc_b_d;
    logic [5:0]    alufun_q,   alufun_d;
    logic          sign_q,     sign_d;
    logic [4:0]    rd_q,       rd_d;
    logic          regwrite_q, regwrite_d;
    logic          memread_q,  memread_d;
    logic          memwrite_q, memwrite_d;

    // Priority: flush > stall > hazard bubble > capture.
    always_comb begin
        valid_d    = valid_q;
        rs_addr_d  = rs_addr_q;
        rt_addr_d  = rt_addr_q;
        rs_data_d  = rs_data_q;
        rt_data_d  = rt_data_q;
        imm_d      = imm_q;
        shamt_d    = shamt_q;
        alusrc_a_d = alusrc_a_q;
        alusrc_b_d = alusrc_b_q;
        alufun_d   = alufun_q;
        sign_d     = sign_q;
        rd_d       = rd_q;
        regwrite_d = regwrite_q;
        memread_d  = memread_q;
        memwrite_d = memwrite_q;
        if (flush || (!stall && hazard_stall)) begin
            valid_d    = 1'b0;
            rs_addr_d  = '0;
            rt_addr_d  = '0;
            rs_data_d  = '0;
            rt_data_d  = '0;
            imm_d      = '0;
            shamt_d    = '0;
            alusrc_a_d = '0;
            alusrc_b_d = 1'b0;
            alufun_d   = '0;
            sign_d     = 1'b0;
            rd_d       = '0;
            regwrite_d = 1'b0;
            memread_d  = 1'b0;
            memwrite_d = 1'b0;
        end else if (!stall) begin
            valid_d    = id_valid;
            rs_addr_d  = id_rs_addr;
            rt_addr_d  = id_rt_addr;
            rs_data_d  = id_rs_data;
            rt_data_d  = id_rt_data;
            imm_d      = id_imm;
            shamt_d    = id_shamt;
            alusrc_a_d = id_alusrc_a;
            alusrc_b_d = id_alusrc_b;
            alufun_d   = id_alufun;
            sign_d     = id_sign;
            rd_d       = id_rd_addr;
            regwrite_d = id_regwrite;
            memread_d  = id_memread;
            memwrite_d = id_memwrite;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q    <= 1'b0;
            rs_addr_q  <= '0;
            rt_addr_q  <= '0;
            rs_data_q  <= '0;
            rt_data_q  <= '0;
            imm_q      <= '0;
            shamt_q    <= '0;
            alusrc_a_q <= '0;
            alusrc_b_q <= 1'b0;
            alufun_q   <= '0;
            sign_q     <= 1'b0;
            rd_q       <= '0;
            regwrite_q <= 1'b0;
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            rs_addr_q  <= rs_addr_d;
            rt_addr_q  <= rt_addr_d;
            rs_data_q  <= rs_data_d;
            rt_data_q  <= rt_data_d;
            imm_q      <= imm_d;
            shamt_q    <= shamt_d;
            alusrc_a_q <= alusrc_a_d;
            alusrc_b_q <= alusrc_b_d;
            alufun_q   <= alufun_d;
            sign_q     <= sign_d;
            rd_q       <= rd_d;
            regwrite_q <= regwrite_d;
            memread_q  <= memread_d;
            memwrite_q <= memwrite_d;
        end
    end

    // ------------------------------------------------------------------
    // Source operand resolution and hazard detection
    // ------------------------------------------------------------------
    logic [DW-1:0] rs_fwd;
    logic [DW-1:0] rt_fwd;

`ifdef OPERAND_FORWARD_EN
    // EX/MEM is the younger writer, so it wins over MEM/WB. $0 is never
    // forwarded because a write to it is architecturally discarded.
    always_comb begin
        rs_fwd = rs_data_q;
        if (exmem_regwrite && (exmem_rd != 5'd0) && (exmem_rd == rs_addr_q)) begin
            rs_fwd = exmem_result;
        end else if (memwb_regwrite && (memwb_rd != 5'd0) && (memwb_rd == rs_addr_q)) begin
            rs_fwd = memwb_result;
        end
        rt_fwd = rt_data_q;
        if (exmem_regwrite && (exmem_rd != 5'd0) && (exmem_rd == rt_addr_q)) begin
            rt_fwd = exmem_result;
        end else if (memwb_regwrite && (memwb_rd != 5'd0) && (memwb_rd == rt_addr_q)) begin
            rt_fwd = memwb_result;
        end
    end

    // Only a load in EX cannot be forwarded in time; one bubble lets it
    // reach MEM/WB, from where the normal forwarding path picks it up.
    assign hazard_stall = valid_q && memread_q && (rd_q != 5'd0) && id_valid &&
                          ((id_use_rs && (id_rs_addr == rd_q)) ||
                           (id_use_rt && (id_rt_addr == rd_q)));
`else
    logic rs_dep;
    logic rt_dep;
    logic unused_fwd_sources;

    assign rs_fwd = rs_data_q;
    assign rt_fwd = rt_data_q;

    // Without forwarding the reader waits until its writer is in WB, where
    // the register file bypass supplies the value during ID.
    assign rs_dep = id_use_rs && (id_rs_addr != 5'd0) &&
                    ((valid_q && regwrite_q && (rd_q == id_rs_addr)) ||
                     (exmem_regwrite && (exmem_rd == id_rs_addr)));
    assign rt_dep = id_use_rt && (id_rt_addr != 5'd0) &&
                    ((valid_q && regwrite_q && (rd_q == id_rt_addr)) ||
                     (exmem_regwrite && (exmem_rd == id_rt_addr)));
    assign hazard_stall = id_valid && (rs_dep || rt_dep);

    assign unused_fwd_sources = ^{exmem_result, memwb_regwrite, memwb_rd,
                                  memwb_result, rs_addr_q, rt_addr_q, memread_q};
`endif

    // ------------------------------------------------------------------
    // ALU operand select and output qualification
    // ------------------------------------------------------------------
    logic [DW-1:0] op_a;
    logic [DW-1:0] op_b;

    always_comb begin
        case (alusrc_a_q)
            2'b01:   op_a = {{(DW-5){1'b0}}, shamt_q};
            2'b10:   op_a = DW'(LUI_SHAMT);
            default: op_a = rs_fwd;   // 2'b11 is reserved and behaves as rs
        endcase
        op_b = alusrc_b_q ? imm_q : rt_fwd;
    end

    assign ex_valid      = valid_q;
    assign ex_a          = valid_q ? op_a     : '0;
    assign ex_b          = valid_q ? op_b     : '0;
    assign ex_store_data = valid_q ? rt_fwd   : '0;
    assign ex_alufun     = valid_q ? alufun_q : '0;
    assign ex_sign       = valid_q && sign_q;
    assign ex_rd         = valid_q ? rd_q     : '0;
    assign ex_regwrite   = valid_q && regwrite_q;
    assign ex_memread    = valid_q && memread_q;
    assign ex_memwrite   = valid_q && memwrite_q;

endmodule
